store_mask_unit: RTL and testbench
==================================

STORE_MASK_UNIT -- requirements
Module: store_mask_unit

Interface
REQ-001 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL have port START  input  1  store request, sampled in IDLE only.
REQ-004 The block SHALL have port CT  input  2  store size: 0 sw (word), 1 sh (halfword), 2 sb (byte), 3 reserved; uses the same encoding as the load mask.
REQ-005 The block SHALL have port ADDR  input  32  target word address, latched on accept.
REQ-006 The block SHALL have port RB  input  32  register data to store, latched on accept.
REQ-007 The block SHALL have port MEM_RD  input  32  memory read data, valid one cycle after MEM_ADDR is presented.
REQ-008 The block SHALL have port MEM_ADDR  output  32  memory address.
REQ-009 The block SHALL have port MEM_WE  output  1  memory write enable.
REQ-010 The block SHALL have port MEM_WD  output  32  memory write data.
REQ-011 The block SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-012 The block SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-013 The block SHALL have port ERR  output  1  one-cycle pulse for a reserved CT.

Function
REQ-014 The FSM SHALL have exactly five states: IDLE, READ, WAIT, WRITE and FINISH, and all outputs SHALL be registered.
REQ-015 In IDLE, when START=1 and CT!=3, the block SHALL latch ADDR, RB and CT and go to READ.
REQ-016 In IDLE, when START=1 and CT=3, the block SHALL pulse ERR for one cycle, stay in IDLE and perform no memory write.
REQ-017 In READ, the block SHALL drive MEM_ADDR with the latched address, hold MEM_WE=0, and go to WAIT.
REQ-018 In WAIT, the block SHALL capture MEM_RD into an internal register MR and go to WRITE.
REQ-019 In WRITE, the block SHALL assert MEM_WE=1 for exactly one cycle with MEM_ADDR at the latched address, then go to FINISH.
REQ-020 The write data in WRITE SHALL be merged as follows:
  - CT=0: MEM_WD=RB.
  - CT=1: MEM_WD={MR[31:16], RB[15:0]}.
  - CT=2: MEM_WD={MR[31:8], RB[7:0]}.
REQ-021 In FINISH, the block SHALL pulse DONE for one cycle and return to IDLE.
REQ-022 Latency SHALL be fixed: if START is sampled at edge k, MEM_WE is high during cycle k+3 and DONE is high during cycle k+4.
REQ-023 START asserted while BUSY=1 SHALL be ignored; no queueing.
REQ-024 A new START asserted during FINISH SHALL NOT be accepted.
REQ-025 A new START asserted in the first IDLE cycle after FINISH SHALL be accepted, giving a back-to-back period of 5 cycles.
REQ-026 Inputs ADDR, RB and CT SHALL be ignored after accept; changing them mid-operation SHALL NOT affect MEM_ADDR or MEM_WD.
REQ-027 MEM_WE SHALL never be asserted in any state other than WRITE.

Reset
REQ-028 While reset=0, the block SHALL force the state to IDLE and MEM_WE=0, DONE=0, ERR=0, BUSY=0, MEM_ADDR=0 and MEM_WD=0, independent of clk.
REQ-029 Reset asserted mid-operation, including during WRITE, SHALL drop MEM_WE immediately and abort the store with no DONE.
REQ-030 After reset is released, the first START SHALL be accepted at the first rising edge.

Configuration
REQ-031 With STORE_MASK_WORD_BYPASS_EN defined, a CT=0 request SHALL skip READ and WAIT (IDLE->WRITE->FINISH), so MEM_WE is high at k+1 and DONE at k+2; CT=1 and CT=2 are unchanged.
REQ-032 With STORE_MASK_WORD_BYPASS_EN undefined, every request, including CT=0, SHALL perform the full read-modify-write sequence per REQ-022.

Verification
REQ-033 The bench SHALL cover a halfword store: ADDR=0x40, MEM_RD=0x11223344, RB=0xAABBCCDD, CT=1 -> MEM_WD=0x1122CCDD, MEM_WE at k+3, DONE at k+4.
REQ-034 The bench SHALL cover a byte store: MEM_RD=0x80000000, RB=0x000000FF, CT=2 -> MEM_WD=0x800000FF, upper bits preserved.
REQ-035 The bench SHALL cover a word store: RB=0xDEADBEEF, CT=0 -> MEM_WD=0xDEADBEEF; MEM_WE at k+3 without the macro and at k+1 with STORE_MASK_WORD_BYPASS_EN.
REQ-036 The bench SHALL cover a reserved size: CT=3 with START -> ERR pulse for 1 cycle, MEM_WE stays 0, BUSY stays 0.
REQ-037 The bench SHALL cover reset mid-operation: reset=0 driven asynchronously during WRITE -> MEM_WE falls before the next edge, no DONE, and BUSY=0.
REQ-038 The bench SHALL cover a busy START: START pulsed at k+1 and k+2 -> ignored, exactly one MEM_WE pulse, and a later START at k+5 is accepted.

Source files
------------

// File: rtl/store_mask_unit_if.sv
// Store request and memory port bundle for store_mask_unit.
// The requester/memory side uses master; the store unit uses slave.
interface store_mask_unit_if;
  logic        START;
  logic [1:0]  CT;
  logic [31:0] ADDR;
  logic [31:0] RB;
  logic [31:0] MEM_RD;
  logic [31:0] MEM_ADDR;
  logic        MEM_WE;
  logic [31:0] MEM_WD;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  modport master (
    output START, CT, ADDR, RB, MEM_RD,
    input  MEM_ADDR, MEM_WE, MEM_WD, BUSY, DONE, ERR
  );

  modport slave (
    input  START, CT, ADDR, RB, MEM_RD,
    output MEM_ADDR, MEM_WE, MEM_WD, BUSY, DONE, ERR
  );
endinterface

// File: rtl/store_mask_unit.sv
// Sub-word store via read-modify-write of a 32-bit memory word (sw/sh/sb).
// Optional macro STORE_MASK_WORD_BYPASS_EN: full-word stores skip the read phase.
module store_mask_unit (
  input  logic              clk,
  input  logic              reset,
  store_mask_unit_if.slave  bus
);

  localparam int unsigned DW  = 32;
  localparam int unsigned CTW = 2;

  localparam logic [CTW-1:0] CT_WORD = CTW'(0);
  localparam logic [CTW-1:0] CT_HALF = CTW'(1);
  localparam logic [CTW-1:0] CT_BYTE = CTW'(2);
  localparam logic [CTW-1:0] CT_RSVD = CTW'(3);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WAIT   = 3'd2,
    S_WRITE  = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  state_e          r_state;
  logic [DW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_rb;
  logic [CTW-1:0]  r_ct;
  logic [DW-1:0]   r_mr;
  logic [DW-1:0]   r_mem_wd;
  logic            r_mem_we;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  // Bits set in the keep mask come from the old memory word, the rest from RB.
  function automatic logic [DW-1:0] merge_data(input logic [CTW-1:0] ct,
                                               input logic [DW-1:0]  old_word,
                                               input logic [DW-1:0]  rb);
    logic [DW-1:0] keep;
    case (ct)
      CT_HALF: keep = DW'(32'hFFFF_0000);
      CT_BYTE: keep = DW'(32'hFFFF_FF00);
      default: keep = '0;
    endcase
    return (old_word & keep) | (rb & ~keep);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_mem_addr <= '0;
      r_rb       <= '0;
      r_ct       <= CT_WORD;
      r_mr       <= '0;
      r_mem_wd   <= '0;
      r_mem_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.START) begin
            if (bus.CT == CT_RSVD) begin
              r_err <= 1'b1;
            end else begin
              r_mem_addr <= bus.ADDR;
              r_rb       <= bus.RB;
              r_ct       <= bus.CT;
              r_busy     <= 1'b1;
`ifdef STORE_MASK_WORD_BYPASS_EN
              if (bus.CT == CT_WORD) begin
                r_mem_wd <= bus.RB;
                r_mem_we <= 1'b1;
                r_state  <= S_WRITE;
              end else begin
                r_state  <= S_READ;
              end
`else
              r_state <= S_READ;
`endif
            end
          end
        end
        S_READ: begin
          r_state <= S_WAIT;
        end
        // Write data is formed from MEM_RD here so it is already registered in WRITE.
        S_WAIT: begin
          r_mr     <= bus.MEM_RD;
          r_mem_wd <= merge_data(r_ct, bus.MEM_RD, r_rb);
          r_mem_we <= 1'b1;
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          r_mem_wd <= merge_data(r_ct, r_mr, r_rb);
          r_done   <= 1'b1;
          r_state  <= S_FINISH;
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.MEM_ADDR = r_mem_addr;
  assign bus.MEM_WE   = r_mem_we;
  assign bus.MEM_WD   = r_mem_wd;
  assign bus.BUSY     = r_busy;
  assign bus.DONE     = r_done;
  assign bus.ERR      = r_err;

endmodule

// File: tb/tb_store_mask_unit.sv
// Bench for store_mask_unit: timeline model plus directed literal checks.
// Honours STORE_MASK_WORD_BYPASS_EN for word-store latency.
module tb_store_mask_unit;

`ifdef STORE_MASK_WORD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
  localparam int WLAT   = 1;
`else
  localparam bit BYPASS = 1'b0;
  localparam int WLAT   = 3;
`endif

  logic clk = 1'b0;
  logic reset;
  store_mask_unit_if bus ();

  store_mask_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] pre [256];

  // Memory returns the preloaded word one cycle after the address is seen.
  always @(posedge clk) bus.MEM_RD <= pre[bus.MEM_ADDR[7:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_merge(input logic [1:0] ct, input logic [31:0] old_w,
                                            input logic [31:0] rb);
    if (ct == 2'd1) return {old_w[31:16], rb[15:0]};
    if (ct == 2'd2) return {old_w[31:8], rb[7:0]};
    return rb;
  endfunction

  function automatic int exp_lat(input logic [1:0] ct);
    return (BYPASS && ct == 2'd0) ? 1 : 3;
  endfunction

  // Model: cycle c is the interval following edge c-1; edge_cnt holds c during a cycle.
  int          edge_cnt = 0;
  int          t_acc    = -100;
  int          t_we     = -100;
  int          t_done   = -100;
  int          t_err    = -100;
  int          t_free   = 0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wd     = '0;
  bit          m_rd     = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_acc  <= -100;
      t_we   <= -100;
      t_done <= -100;
      t_err  <= -100;
      t_free <= 0;
    end else begin
      if (bus.START && edge_cnt >= t_free) begin
        if (bus.CT == 2'd3) begin
          t_err <= edge_cnt + 1;
        end else begin
          t_acc  <= edge_cnt;
          t_we   <= edge_cnt + exp_lat(bus.CT);
          t_done <= edge_cnt + exp_lat(bus.CT) + 1;
          t_free <= edge_cnt + exp_lat(bus.CT) + 2;
          m_addr <= bus.ADDR;
          m_wd   <= exp_merge(bus.CT, pre[bus.ADDR[7:0]], bus.RB);
          m_rd   <= (exp_lat(bus.CT) == 3);
        end
      end
      edge_cnt <= edge_cnt + 1;
    end
  end

  always @(negedge clk) begin
    check("cyc_we",   32'(bus.MEM_WE), 32'(edge_cnt == t_we));
    check("cyc_done", 32'(bus.DONE),   32'(edge_cnt == t_done));
    check("cyc_err",  32'(bus.ERR),    32'(edge_cnt == t_err));
    check("cyc_busy", 32'(bus.BUSY),   32'(edge_cnt > t_acc && edge_cnt <= t_done));
    if (edge_cnt == t_we) begin
      check("cyc_wd",      bus.MEM_WD,   m_wd);
      check("cyc_wr_addr", bus.MEM_ADDR, m_addr);
    end
    if (m_rd && edge_cnt == t_acc + 1) check("cyc_rd_addr", bus.MEM_ADDR, m_addr);
  end

  task automatic drive(input logic st, input logic [1:0] ct, input logic [31:0] a,
                       input logic [31:0] rb);
    bus.START = st;
    bus.CT    = ct;
    bus.ADDR  = a;
    bus.RB    = rb;
  endtask

  // Returns at the falling edge of cycle k+1, k being the accepting edge.
  task automatic issue(input logic [1:0] ct, input logic [31:0] a, input logic [31:0] rb);
    @(negedge clk);
    drive(1'b1, ct, a, rb);
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  int we_cnt;

  initial begin
    for (int i = 0; i < 256; i++) pre[i] = 32'h0;
    pre[8'h40] = 32'h1122_3344;
    pre[8'h10] = 32'h8000_0000;
    pre[8'h30] = 32'hCAFE_F00D;
    reset = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_we",   32'(bus.MEM_WE), 32'd0);
    check("rst_done", 32'(bus.DONE),   32'd0);
    check("rst_err",  32'(bus.ERR),    32'd0);
    check("rst_busy", 32'(bus.BUSY),   32'd0);
    check("rst_addr", bus.MEM_ADDR,    32'h0);
    check("rst_wd",   bus.MEM_WD,      32'h0);

    // Halfword store accepted on the first edge after release; inputs scrambled afterwards.
    reset = 1'b1;
    drive(1'b1, 2'd1, 32'h40, 32'hAABB_CCDD);
    @(negedge clk);
    drive(1'b0, 2'd2, 32'h99, 32'h0);
    check("hw_busy", 32'(bus.BUSY), 32'd1);
    repeat (2) @(negedge clk);
    check("hw_we",   32'(bus.MEM_WE), 32'd1);
    check("hw_wd",   bus.MEM_WD,      32'h1122_CCDD);
    check("hw_addr", bus.MEM_ADDR,    32'h40);
    @(negedge clk);
    check("hw_done", 32'(bus.DONE),   32'd1);
    check("hw_we_off", 32'(bus.MEM_WE), 32'd0);
    @(negedge clk);
    check("hw_idle", 32'(bus.BUSY),   32'd0);

    issue(2'd2, 32'h10, 32'h0000_00FF);
    repeat (2) @(negedge clk);
    check("sb_we", 32'(bus.MEM_WE), 32'd1);
    check("sb_wd", bus.MEM_WD,      32'h8000_00FF);
    @(negedge clk);
    check("sb_done", 32'(bus.DONE), 32'd1);

    issue(2'd0, 32'h20, 32'hDEAD_BEEF);
    repeat (WLAT - 1) @(negedge clk);
    check("sw_we", 32'(bus.MEM_WE), 32'd1);
    check("sw_wd", bus.MEM_WD,      32'hDEAD_BEEF);
    @(negedge clk);
    check("sw_done", 32'(bus.DONE), 32'd1);
    repeat (2) @(negedge clk);

    issue(2'd3, 32'h50, 32'h1234_5678);
    check("rsv_err",  32'(bus.ERR),    32'd1);
    check("rsv_busy", 32'(bus.BUSY),   32'd0);
    check("rsv_we",   32'(bus.MEM_WE), 32'd0);
    @(negedge clk);
    check("rsv_err_off", 32'(bus.ERR), 32'd0);
    check("rsv_we2", 32'(bus.MEM_WE),  32'd0);

    // START held over edges k..k+2 and again at k+4 (FINISH) and k+5 (IDLE).
    @(negedge clk);
    drive(1'b1, 2'd1, 32'h30, 32'h0000_BEEF);
    @(negedge clk);
    we_cnt = int'(bus.MEM_WE);
    drive(1'b1, 2'd0, 32'h77, 32'h0);
    @(negedge clk);
    we_cnt += int'(bus.MEM_WE);
    @(negedge clk);
    we_cnt += int'(bus.MEM_WE);
    check("bz_wd", bus.MEM_WD, 32'hCAFE_BEEF);
    bus.START = 1'b0;
    @(negedge clk);
    we_cnt += int'(bus.MEM_WE);
    check("bz_done", 32'(bus.DONE), 32'd1);
    drive(1'b1, 2'd2, 32'h40, 32'h5555_AAAA);
    @(negedge clk);
    we_cnt += int'(bus.MEM_WE);
    check("bz_finish_rej", 32'(bus.BUSY), 32'd0);
    @(negedge clk);
    we_cnt += int'(bus.MEM_WE);
    bus.START = 1'b0;
    check("bz_accept", 32'(bus.BUSY), 32'd1);
    check("bz_one_we", 32'(we_cnt), 32'd1);
    repeat (2) @(negedge clk);
    check("bz2_we", 32'(bus.MEM_WE), 32'd1);
    check("bz2_wd", bus.MEM_WD,      32'h1122_33AA);
    @(negedge clk);
    check("bz2_done", 32'(bus.DONE), 32'd1);

    // Asynchronous reset in the middle of the WRITE cycle.
    issue(2'd2, 32'h30, 32'h0000_0077);
    repeat (2) @(negedge clk);
    check("ab_we", 32'(bus.MEM_WE), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("ab_we_drop", 32'(bus.MEM_WE), 32'd0);
    check("ab_busy",    32'(bus.BUSY),   32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ab_no_done", 32'(bus.DONE), 32'd0);
    end

    issue(2'd1, 32'h10, 32'h0000_1234);
    repeat (2) @(negedge clk);
    check("post_wd", bus.MEM_WD, 32'h8000_1234);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
